// File: rtl/dmem_arb_pkg.sv
// Shared types, requester ids and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_CLEAR_DEPTH  = 1024;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Width needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Post-reset zero-fill sequencer: walks addresses 0..CLEAR_DEPTH-1 writing zero,
// holding busy high until the last word has been written.
module dmem_clear_seq
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CLEAR_DEPTH = DEF_CLEAR_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_a,
  output logic              clr_we,
  output logic [DATA_W-1:0] clr_wd
);

  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;

  assign clr_last = (clr_cnt == ADDR_W'(CLEAR_DEPTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      if (clr_last) busy <= 1'b0;
    end
  end

  // The write strobe is masked by reset so the RAM is never written while held.
  assign clr_a  = clr_cnt;
  assign clr_we = busy && reset;
  assign clr_wd = '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the MEM-stage CPU port and a debug port.
// Define DMEM_ARB_CLEAR_EN to include the post-reset zero-fill sequencer.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLEAR_DEPTH  = DEF_CLEAR_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [31:0]       ram_a,
  output logic [DATA_W-1:0] ram_wd,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rd,
  output logic              busy
);

  localparam int SW = cnt_width(STARVE_LIMIT);

  state_t            state;
  logic [ADDR_W-1:0] clr_a;
  logic              clr_we;
  logic [DATA_W-1:0] clr_wd;
  logic [SW-1:0]     starve_cnt;
  logic              arb_en;
  logic              contest;
  logic              dbg_win;
  logic              owner;
  logic              unused_addr_hi;

`ifdef DMEM_ARB_CLEAR_EN
  dmem_clear_seq #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .CLEAR_DEPTH (CLEAR_DEPTH)
  ) u_clear_seq (
    .clk    (clk),
    .reset  (reset),
    .busy   (busy),
    .clr_a  (clr_a),
    .clr_we (clr_we),
    .clr_wd (clr_wd)
  );
  assign state = busy ? ST_CLEAR : ST_ARB;
`else
  localparam int unused_clear_depth = CLEAR_DEPTH;
  assign busy   = 1'b0;
  assign clr_a  = '0;
  assign clr_we = 1'b0;
  assign clr_wd = '0;
  assign state  = ST_ARB;
`endif

  // Only the low ADDR_W address bits reach the RAM.
  assign unused_addr_hi = ^{cpu_addr[31:ADDR_W], dbg_addr[31:ADDR_W]};

  assign arb_en  = (state == ST_ARB) && reset;
  assign contest = cpu_req && dbg_req;
  assign dbg_win = dbg_req && (!cpu_req || (starve_cnt == SW'(STARVE_LIMIT)));
  assign cpu_gnt = arb_en && cpu_req && !dbg_win;
  assign dbg_gnt = arb_en && dbg_win;
  assign owner   = dbg_win ? REQ_DBG : REQ_CPU;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ram_a  = '0;
    ram_wd = '0;
    ram_we = 1'b0;
    if (state == ST_CLEAR) begin
      ram_a  = 32'(clr_a);
      ram_wd = clr_wd;
      ram_we = clr_we;
    end else if (cpu_gnt || dbg_gnt) begin
      if (owner == REQ_DBG) begin
        ram_a  = 32'(dbg_addr[ADDR_W-1:0]);
        ram_wd = dbg_wdata;
        ram_we = dbg_we;
      end else begin
        ram_a  = 32'(cpu_addr[ADDR_W-1:0]);
        ram_wd = cpu_wdata;
        ram_we = cpu_we;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dbg_rvalid <= dbg_gnt && !dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= ram_rd;
      if (dbg_gnt && !dbg_we) dbg_rdata <= ram_rd;
      // Count consecutive contested CPU wins; any DBG grant resets the guard.
      if (dbg_gnt) begin
        starve_cnt <= '0;
      end else if (cpu_gnt && contest && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Controller that sequences and shares the single-port data memory of the pipelined MIPS core between two requesters: the MEM-stage load/store port (CPU) and a debug/loader port (DBG). After reset it optionally zero-fills the memory with a clear sequencer. It then grants at most one access per cycle, giving CPU priority with a starvation guard for DBG. It sits between the pipeline's MEM stage and the data RAM, and is the only driver of the RAM's address, write-data and write-enable inputs.

## Interface
- ADDR_W, 10, word-address width actually driven to the RAM
- DATA_W, 32, data width
- CLEAR_DEPTH, 1024, number of words zeroed by the clear sequencer
- STARVE_LIMIT, 4, consecutive contested CPU wins before DBG is forced through
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req / cpu_we  in  1 / 1  CPU access request / write (1) or read (0)
- cpu_addr / cpu_wdata  in  32 / DATA_W  CPU word address / write data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid / cpu_rdata  out  1 / DATA_W  read-data pulse / registered read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same as CPU set, for DBG
- ram_a  out  32  RAM address, zero-extended from ADDR_W bits
- ram_wd  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_rd  in  DATA_W  RAM combinational read data
- busy  out  1  clear sequence in progress

## Operation
- Two states: CLEAR and ARB. Reset enters CLEAR when the clear sequencer is compiled in, otherwise ARB.
- CLEAR
  - ram_we=1, ram_wd=0, ram_a=clr_cnt; busy=1; both gnt=0.
  - clr_cnt increments every cycle. After the cycle with clr_cnt=CLEAR_DEPTH-1, go to ARB and clear busy.
  - Requests are ignored, not queued; requesters keep req high until granted.
- ARB
  - Grant is combinational in the same cycle as req. At most one gnt per cycle.
  - Only CPU requests: CPU granted. Only DBG requests: DBG granted.
  - Both request: CPU wins unless starve_cnt==STARVE_LIMIT, in which case DBG wins.
- starve_cnt
  - Increments on each contested cycle CPU wins, saturating at STARVE_LIMIT.
  - Clears to 0 whenever DBG is granted.
  - Holds when there is no contest.
- Granted access
  - ram_a = zero-extended addr[ADDR_W-1:0]; upper address bits are ignored.
  - Write: ram_we = we, ram_wd = wdata.
  - Read: ram_we=0. The requester's rdata register captures ram_rd at the clock edge, and its rvalid pulses high for exactly one cycle.
- No grant: ram_we=0, ram_a=0, ram_wd=0.
- Each requester's rdata holds its last value until its next read.

## Timing
- Reset values: cpu_gnt=dbg_gnt=0, cpu_rvalid=dbg_rvalid=0, cpu_rdata=dbg_rdata=0, ram_we=0, clr_cnt=0, starve_cnt=0. busy=1 with the clear sequencer compiled in, otherwise 0.
- Write latency: RAM is updated at the edge ending the grant cycle.
- Read latency: 1 cycle; rvalid is high the cycle after gnt.
- Back-to-back grants are allowed every cycle. A read in cycle N+1 to an address written in cycle N returns the new data.
- Clear duration is exactly CLEAR_DEPTH cycles; the first grant is possible in cycle CLEAR_DEPTH after reset deassertion.
- Reset asserted mid-clear or mid-access: outputs drop to reset values immediately and the clear restarts from address 0.
- Reset asserted in the cycle a read was granted: the pending rvalid is discarded.

## Configuration
- DMEM_ARB_CLEAR_EN defined: the CLEAR state and clr_cnt exist; busy behaves as described above.
- DMEM_ARB_CLEAR_EN not defined: the block resets directly into ARB; busy is tied to 0; clr_cnt logic is absent; the first grant is possible in the first cycle after reset.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (ST_CLEAR, ST_ARB)
  - requester id constants (REQ_CPU=0, REQ_DBG=1)
  - default values for ADDR_W, DATA_W, CLEAR_DEPTH and STARVE_LIMIT
- One sub-module, dmem_clear_seq, owns clr_cnt and busy and produces the clear-phase address, data and write enable. It is instantiated only under DMEM_ARB_CLEAR_EN.

## Test plan
- Reset with clear enabled, CLEAR_DEPTH=1024 -> busy high for 1024 cycles; ram_we=1 with ram_a stepping 0..1023; no gnt during clear; busy=0 in cycle 1024.
- CPU writes 0xDEADBEEF to address 5, then reads address 5 -> cpu_gnt in both cycles; cpu_rvalid one cycle after the read grant with cpu_rdata=0xDEADBEEF.
- CPU and DBG both requesting continuously -> grant pattern CPU,CPU,CPU,CPU,DBG repeating; starve_cnt returns to 0 after each DBG grant.
- DBG reads address 0x405 (ADDR_W=10) -> ram_a=0x005.
- Reset asserted at clear count 300 -> count restarts at 0 and busy stays high for a further full 1024 cycles.
- Build without DMEM_ARB_CLEAR_EN; CPU requests in the first cycle after reset -> cpu_gnt=1 immediately and busy=0 throughout.
